// File: rtl/ram_port_arbiter.sv
// Arbitrates the 16x8 program/data RAM between the CPU datapath and an external loader.
// Define ARB_STALL_CNT_EN to add a saturating stall_cnt output counting CPU stall cycles.
module ram_port_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int LDR_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ram_ce_n,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [7:0]        stall_cnt
`endif
);

  localparam int CNT_W = $clog2(LDR_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(LDR_BURST);

  typedef enum logic [2:0] {
    PARK_CPU,
    LDR_ACC,
    LDR_DONE,
    LDR_GNT,
    TURN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic                lat_we_q, lat_we_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic                ldr_gnt_q, ldr_gnt_d;
  logic                ldr_ack_q, ldr_ack_d;
  logic                at_limit;

  // The burst count only forces a release while the CPU is actually waiting.
  assign at_limit = (burst_cnt_q == BURST_MAX);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      PARK_CPU: begin
        if (ldr_req && !cpu_req) begin
          state_d     = LDR_ACC;
          lat_we_d    = ldr_we;
          lat_addr_d  = ldr_addr;
          lat_wdata_d = ldr_wdata;
          burst_cnt_d = CNT_W'(1);
        end
      end
      LDR_ACC: begin
        ldr_rdata_d = ram_rdata;
        state_d     = LDR_DONE;
      end
      LDR_DONE: begin
        state_d = (cpu_req && at_limit) ? TURN : LDR_GNT;
      end
      LDR_GNT: begin
        if (ldr_req && !(cpu_req && at_limit)) begin
          state_d     = LDR_ACC;
          lat_we_d    = ldr_we;
          lat_addr_d  = ldr_addr;
          lat_wdata_d = ldr_wdata;
          if (!at_limit) burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
          state_d = TURN;
        end
      end
      TURN: begin
        burst_cnt_d = '0;
        state_d     = PARK_CPU;
      end
      default: begin
        state_d     = PARK_CPU;
        burst_cnt_d = '0;
      end
    endcase
    ldr_gnt_d = (state_d == LDR_ACC) || (state_d == LDR_DONE) || (state_d == LDR_GNT);
    ldr_ack_d = (state_d == LDR_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PARK_CPU;
      burst_cnt_q <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      ldr_rdata_q <= '0;
      ldr_gnt_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      ldr_gnt_q   <= ldr_gnt_d;
      ldr_ack_q   <= ldr_ack_d;
    end
  end

  // CPU path is a zero-latency passthrough while parked; loader only drives RAM in LDR_ACC.
  always_comb begin
    ram_ce_n  = 1'b1;
    ram_we_n  = 1'b1;
    ram_addr  = lat_addr_q;
    ram_wdata = lat_wdata_q;
    case (state_q)
      PARK_CPU: begin
        ram_ce_n  = ~cpu_req;
        ram_we_n  = ~(cpu_req & cpu_we);
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      LDR_ACC: begin
        ram_ce_n = 1'b0;
        ram_we_n = ~lat_we_q;
      end
      default: begin
        ram_ce_n = 1'b1;
        ram_we_n = 1'b1;
      end
    endcase
  end

  assign cpu_rdata = ram_rdata;
  assign cpu_stall = cpu_req && (state_q != PARK_CPU);
  assign ldr_gnt   = ldr_gnt_q;
  assign ldr_ack   = ldr_ack_q;
  assign ldr_rdata = ldr_rdata_q;

`ifdef ARB_STALL_CNT_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_stall && (stall_cnt_q != 8'hFF)) stall_cnt_d = stall_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 8'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: RAM model, loader scoreboard and scenario tasks.
// Build with +define+ARB_STALL_CNT_EN to also exercise the stall counter.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       ldr_req = 1'b0, ldr_we = 1'b0;
  logic [3:0] ldr_addr = '0;
  logic [7:0] ldr_wdata = '0;
  logic       ldr_gnt, ldr_ack;
  logic [7:0] ldr_rdata;
  logic       ram_ce_n, ram_we_n;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
`ifdef ARB_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  ram_port_arbiter #(.ADDR_W(4), .DATA_W(8), .LDR_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Asynchronous-read, synchronous-write 16x8 RAM
  logic [7:0] mem [16] = '{default: 8'h00};
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (!ram_ce_n && !ram_we_n) mem[ram_addr] <= ram_wdata;

  typedef struct {
    logic       is_read;
    logic [7:0] data;
  } sb_t;

  sb_t        sb_q[$];
  sb_t        sb_head;
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         sb_en = 1'b1;

  // Each loader ack retires the oldest outstanding request; reads carry expected data
  always @(negedge clk) begin
    #1;
    if (sb_en && ldr_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("[TB] FAIL sb_unexpected_ack: got ack with empty queue, required no ack");
      end else begin
        sb_head = sb_q.pop_front();
        if (sb_head.is_read) begin
          n_cmp++;
          if (ldr_rdata !== sb_head.data) begin
            n_fail++;
            $display("[TB] FAIL sb_ldr_rdata: got %h, required %h", ldr_rdata, sb_head.data);
          end
        end
      end
    end
  end

  task automatic ldr_drive(input logic we, input logic [3:0] addr, input logic [7:0] data);
    sb_t e;
    ldr_req   = 1'b1;
    ldr_we    = we;
    ldr_addr  = addr;
    ldr_wdata = data;
    e.is_read = ~we;
    e.data    = we ? 8'h00 : ref_mem[addr];
    if (we) ref_mem[addr] = data;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h0;
    #1;
    n_cmp++;
    if ({ldr_gnt, ldr_ack, ram_ce_n, cpu_stall} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b, required 0000", {ldr_gnt, ldr_ack, ram_ce_n, cpu_stall});
    end
    n_cmp++;
    if (ldr_rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h, required 00", ldr_rdata); end
`ifdef ARB_STALL_CNT_EN
    n_cmp++;
    if (stall_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_stall_cnt: got %0d, required 0", stall_cnt); end
`endif
    cpu_req = 1'b0;
    #1;
    n_cmp++;
    if ({ram_ce_n, ram_we_n} !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_ram_idle: got %b, required 11", {ram_ce_n, ram_we_n}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); ldr_drive(1'b1, 4'h5, 8'h77);
    #1;
    n_cmp++;
    if (ldr_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pre_gnt: got %b, required 0", ldr_gnt); end
    @(negedge clk); #1;
    n_cmp++;
    if ({ldr_gnt, ram_ce_n} !== 2'b10) begin n_fail++; $display("[TB] FAIL reset_acc_state: got %b, required 10", {ldr_gnt, ram_ce_n}); end
    #1; rst = 1'b1; cpu_req = 1'b1;
    #1;
    n_cmp++;
    if ({ldr_gnt, ldr_ack, ram_ce_n, cpu_stall} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_midburst: got %b, required 0000", {ldr_gnt, ldr_ack, ram_ce_n, cpu_stall});
    end
    sb_q.delete();
    ref_mem[5] = 8'h00;
    ldr_req = 1'b0; cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({ldr_ack, ldr_gnt} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_no_ack: cycle %0d got %b, required 00", i, {ldr_ack, ldr_gnt}); end
    end
    n_cmp++;
    if (mem[5] !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_dropped_write: got %h, required 00", mem[5]); end
  endtask

  task automatic test_cpu_access();
    do_reset();
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'hE; cpu_wdata = 8'h2C; ref_mem[14] = 8'h2C;
    #1;
    n_cmp++;
    if ({ram_ce_n, ram_we_n, cpu_stall, ram_addr, ram_wdata} !== {3'b000, 4'hE, 8'h2C}) begin
      n_fail++; $display("[TB] FAIL cpu_write_E: got %b %h %h, required 000 e 2c", {ram_ce_n, ram_we_n, cpu_stall}, ram_addr, ram_wdata);
    end
    @(negedge clk); cpu_we = 1'b0;
    #1;
    n_cmp++;
    if ({ram_ce_n, ram_we_n, cpu_stall, cpu_rdata} !== {3'b010, 8'h2C}) begin
      n_fail++; $display("[TB] FAIL cpu_read_E: got %b %h, required 010 2c", {ram_ce_n, ram_we_n, cpu_stall}, cpu_rdata);
    end
    @(negedge clk); cpu_we = 1'b1; cpu_addr = 4'h2; cpu_wdata = 8'h5A; ref_mem[2] = 8'h5A;
    @(negedge clk); cpu_we = 1'b0;
    #1;
    n_cmp++;
    if (cpu_rdata !== 8'h5A) begin n_fail++; $display("[TB] FAIL cpu_read_2: got %h, required 5a", cpu_rdata); end
    @(negedge clk); cpu_req = 1'b0;
    #1;
    n_cmp++;
    if ({ram_ce_n, ram_we_n, ldr_gnt} !== 3'b110) begin n_fail++; $display("[TB] FAIL cpu_idle: got %b, required 110", {ram_ce_n, ram_we_n, ldr_gnt}); end
  endtask

  task automatic test_ldr_write_read();
    do_reset();
    @(negedge clk); ldr_drive(1'b1, 4'h3, 8'hA5);
    #1;
    n_cmp++;
    if (ldr_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL lwr_accept_gnt: got %b, required 0", ldr_gnt); end
    @(negedge clk); ldr_wdata = 8'hFF;
    #1;
    n_cmp++;
    if ({ldr_gnt, ldr_ack, ram_ce_n, ram_we_n, ram_addr, ram_wdata} !== {4'b1000, 4'h3, 8'hA5}) begin
      n_fail++; $display("[TB] FAIL lwr_write_cycle: got %b %h %h, required 1000 3 a5", {ldr_gnt, ldr_ack, ram_ce_n, ram_we_n}, ram_addr, ram_wdata);
    end
    @(negedge clk); ldr_drive(1'b0, 4'h3, 8'h00);
    #1;
    n_cmp++;
    if ({ldr_gnt, ldr_ack, ram_ce_n} !== 3'b111) begin n_fail++; $display("[TB] FAIL lwr_write_ack: got %b, required 111", {ldr_gnt, ldr_ack, ram_ce_n}); end
    @(negedge clk); #1;
    n_cmp++;
    if ({ldr_gnt, ldr_ack, ram_ce_n} !== 3'b101) begin n_fail++; $display("[TB] FAIL lwr_gnt_idle: got %b, required 101", {ldr_gnt, ldr_ack, ram_ce_n}); end
    @(negedge clk); #1;
    n_cmp++;
    if ({ldr_ack, ram_ce_n, ram_we_n, ram_addr} !== {3'b001, 4'h3}) begin
      n_fail++; $display("[TB] FAIL lwr_read_cycle: got %b %h, required 001 3", {ldr_ack, ram_ce_n, ram_we_n}, ram_addr);
    end
    @(negedge clk); ldr_req = 1'b0;
    #1;
    n_cmp++;
    if ({ldr_ack, ldr_rdata} !== {1'b1, 8'hA5}) begin n_fail++; $display("[TB] FAIL lwr_read_ack: got %b %h, required 1 a5", ldr_ack, ldr_rdata); end
    n_cmp++;
    if (mem[3] !== 8'hA5) begin n_fail++; $display("[TB] FAIL lwr_ram_content: got %h, required a5", mem[3]); end
    @(negedge clk); #1;
    n_cmp++;
    if (ldr_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL lwr_last_gnt: got %b, required 1", ldr_gnt); end
    @(negedge clk); #1;
    n_cmp++;
    if (ldr_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL lwr_turn: got %b, required 0", ldr_gnt); end
    @(negedge clk);
  endtask

  task automatic test_collision();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'hE;
        ldr_drive(1'b1, 4'h7, 8'h3C);
      end
      if (c == 3) cpu_req = 1'b0;
      if (c == 5) ldr_req = 1'b0;
      #1;
      if (c < 3) begin
        n_cmp++;
        if ({cpu_stall, ldr_gnt, ram_ce_n, ram_addr, cpu_rdata} !== {3'b000, 4'hE, 8'h2C}) begin
          n_fail++; $display("[TB] FAIL coll_cpu_wins: cycle %0d got %b %h %h, required 000 e 2c", c, {cpu_stall, ldr_gnt, ram_ce_n}, ram_addr, cpu_rdata);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({ldr_gnt, ram_ce_n} !== 2'b01) begin n_fail++; $display("[TB] FAIL coll_release: got %b, required 01", {ldr_gnt, ram_ce_n}); end
      end
      if (c == 4) begin
        n_cmp++;
        if ({ldr_gnt, ram_we_n, ram_addr} !== {2'b10, 4'h7}) begin
          n_fail++; $display("[TB] FAIL coll_ldr_access: got %b %h, required 10 7", {ldr_gnt, ram_we_n}, ram_addr);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (mem[7] !== 8'h3C) begin n_fail++; $display("[TB] FAIL coll_ram_content: got %h, required 3c", mem[7]); end
      end
      if (c == 8) begin
        n_cmp++;
        if (ldr_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL coll_parked: got %b, required 0", ldr_gnt); end
      end
    end
  endtask

  task automatic test_burst_limit();
    int  acks;
    bit  exp_gnt, exp_ack, exp_stall;
    acks = 0;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      case (c)
        0:  ldr_drive(1'b1, 4'h8, 8'h10);
        2:  ldr_drive(1'b1, 4'h9, 8'h11);
        5:  ldr_drive(1'b1, 4'hA, 8'h12);
        8:  ldr_drive(1'b1, 4'hB, 8'h13);
        11: ldr_drive(1'b1, 4'hC, 8'h14);
        16: ldr_drive(1'b0, 4'h9, 8'h00);
        19: ldr_req = 1'b0;
        default: ;
      endcase
      if (c == 4) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'hE; end
      if (c == 14) cpu_req = 1'b0;
      #1;
      exp_gnt   = (c >= 1 && c <= 11) || (c >= 15 && c <= 20);
      exp_ack   = (c == 2) || (c == 5) || (c == 8) || (c == 11) || (c == 16) || (c == 19);
      exp_stall = (c >= 4 && c <= 12);
      if (c <= 13 && ldr_ack === 1'b1) acks++;
      n_cmp++;
      if ({ldr_gnt, ldr_ack, cpu_stall} !== {exp_gnt, exp_ack, exp_stall}) begin
        n_fail++; $display("[TB] FAIL burst_cycle: cycle %0d got gnt/ack/stall %b, required %b", c, {ldr_gnt, ldr_ack, cpu_stall}, {exp_gnt, exp_ack, exp_stall});
      end
      if (c == 13) begin
        n_cmp++;
        if ({ram_ce_n, ram_addr, cpu_rdata} !== {1'b0, 4'hE, 8'h2C}) begin
          n_fail++; $display("[TB] FAIL burst_cpu_resume: got %b %h %h, required 0 e 2c", ram_ce_n, ram_addr, cpu_rdata);
        end
      end
`ifdef ARB_STALL_CNT_EN
      if (c == 13 || c == 22) begin
        n_cmp++;
        if (stall_cnt !== 8'd9) begin n_fail++; $display("[TB] FAIL burst_stall_cnt: cycle %0d got %0d, required 9", c, stall_cnt); end
      end
`endif
    end
    n_cmp++;
    if (acks !== 4) begin n_fail++; $display("[TB] FAIL burst_ack_count: got %0d, required 4", acks); end
  endtask

`ifdef ARB_STALL_CNT_EN
  task automatic test_stall_sat();
    do_reset();
    sb_en = 1'b0;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h1; ldr_wdata = 8'h00;
    // Each round: loader gets in while CPU idles, then CPU waits out a full burst (12 stalls)
    for (int r = 0; r < 26; r++) begin
      @(negedge clk); cpu_req = 1'b0;
      #1;
      if (r == 10) begin
        n_cmp++;
        if (stall_cnt !== 8'd120) begin n_fail++; $display("[TB] FAIL sat_midway: got %0d, required 120", stall_cnt); end
      end
      for (int k = 0; k < 13; k++) begin
        @(negedge clk); cpu_req = 1'b1;
      end
    end
    @(negedge clk); cpu_req = 1'b0; ldr_req = 1'b0;
    #1;
    n_cmp++;
    if (stall_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_limit: got %0d, required 255", stall_cnt); end
    repeat (6) @(negedge clk);
    sb_q.delete();
    sb_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_access();
    test_ldr_write_read();
    test_collision();
    test_burst_limit();
`ifdef ARB_STALL_CNT_EN
    test_stall_sat();
`endif
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() !== 0) begin n_fail++; $display("[TB] FAIL sb_drain: got %0d pending, required 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
